// File: rtl/temp_ctrl_pkg.sv
// rtl/temp_ctrl_pkg.sv - shared status encoding and sample width for the climate controller
package temp_ctrl_pkg;

    // Default sample/setpoint width, unsigned, in 0.5 degC units
    localparam int TEMP_W = 10;

    // Panel status encoding; the FSM state register uses it directly
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_HEATING = 2'b01;
    localparam logic [1:0] ST_COOLING = 2'b10;
    localparam logic [1:0] ST_ERROR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_HEATING = ST_HEATING,
        S_COOLING = ST_COOLING,
        S_ERROR   = ST_ERROR
    } state_e;

endpackage

// File: rtl/sample_watchdog.sv
// rtl/sample_watchdog.sv - sensor sample watchdog with terminal-count output
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   clear_i     - sample strobe; clears the counter
//   expired_o   - counter at TIMEOUT_CYCLES-1 with no sample this cycle
module sample_watchdog #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at terminal count so expiry stays asserted until a sample arrives
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != TC) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A sample arriving on the terminal cycle wins over expiry
    assign expired_o = (cnt_q == TC) && !clear_i;

endmodule

// File: rtl/temp_control_fsm.sv
// rtl/temp_control_fsm.sv - greenhouse heater/cooler controller with hysteresis and sensor watchdog
//
// Optional feature macro: TEMP_CTRL_DWELL_EN (anti-short-cycle dwell between IDLE/HEATING/COOLING).
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   temp_valid     - one-cycle sample strobe (always accepted)
//   temp_data      - measured temperature
//   temp_fault     - sensor fault, qualified by temp_valid
//   setpoint, hyst - target and band half-width, used only with the sample
//   status         - registered state: 00 idle, 01 heating, 10 cooling, 11 error
//   heater_on      - high iff status == 01
//   cooler_on      - high iff status == 10
//   status_change  - one-cycle pulse when status takes a new value
module temp_control_fsm
    import temp_ctrl_pkg::*;
#(
    parameter int TEMP_W         = temp_ctrl_pkg::TEMP_W,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int DWELL_CYCLES   = 250_000_000,
    parameter int GOOD_SAMPLES   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    input  logic              temp_fault,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [5:0]        hyst,
    output logic [1:0]        status,
    output logic              heater_on,
    output logic              cooler_on,
    output logic              status_change
);

    localparam int TW1   = TEMP_W + 1;
    localparam int GOOD_W = $clog2(GOOD_SAMPLES + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_SAMPLES - 1);
    localparam logic [TEMP_W:0]   T_MAX     = {1'b0, {TEMP_W{1'b1}}};

    state_e            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              heater_q, cooler_q, change_q;
    logic              wd_expired;
    logic              dwell_ok;

    logic [TEMP_W:0] sp_x, hy_x, td_x, sum_x, lo_x, hi_x;

    sample_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (temp_valid),
        .expired_o(wd_expired)
    );

    // Thresholds in one extra bit so both clamps can be detected
    always_comb begin
        sp_x  = {1'b0, setpoint};
        hy_x  = TW1'(hyst);
        td_x  = {1'b0, temp_data};
        sum_x = sp_x + hy_x;
        lo_x  = (sp_x < hy_x) ? '0 : (sp_x - hy_x);
        hi_x  = (sum_x > T_MAX) ? T_MAX : sum_x;
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (temp_valid) begin
            if (temp_fault) begin
                state_d = S_ERROR;
                good_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (dwell_ok && (td_x < lo_x)) begin
                            state_d = S_HEATING;
                        end else if (dwell_ok && (td_x > hi_x)) begin
                            state_d = S_COOLING;
                        end
                    end
                    S_HEATING: begin
                        if (dwell_ok && (td_x >= sp_x)) begin
                            state_d = S_IDLE;
                        end
                    end
                    S_COOLING: begin
                        if (dwell_ok && (td_x <= sp_x)) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        // ERROR exit is never held off by dwell
                        if (good_q == GOOD_LAST) begin
                            state_d = S_IDLE;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                endcase
            end
        end else if (wd_expired) begin
            state_d = S_ERROR;
            good_d  = '0;
        end
    end

`ifdef TEMP_CTRL_DWELL_EN
    localparam int DW_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES);

    logic [DW_W-1:0] dwell_q, dwell_d;

    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != DW_MAX) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign dwell_ok = (dwell_q == DW_MAX);
`else
    logic unused_dwell;
    assign unused_dwell = (DWELL_CYCLES != 0);
    assign dwell_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            good_q   <= '0;
            heater_q <= 1'b0;
            cooler_q <= 1'b0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            heater_q <= (state_d == S_HEATING);
            cooler_q <= (state_d == S_COOLING);
            change_q <= (state_d != state_q);
        end
    end

    assign status        = state_q;
    assign heater_on     = heater_q;
    assign cooler_on     = cooler_q;
    assign status_change = change_q;

endmodule

// File: tb/tb_temp_control_fsm.sv
// tb/tb_temp_control_fsm.sv - directed self-checking bench for temp_control_fsm
module tb_temp_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       temp_valid = 1'b0;
    logic [9:0] temp_data = '0;
    logic       temp_fault = 1'b0;
    logic [9:0] setpoint = 10'd50;
    logic [5:0] hyst = 6'd4;
    logic [1:0] status;
    logic       heater_on;
    logic       cooler_on;
    logic       status_change;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    temp_control_fsm #(
        .TEMP_W        (10),
        .TIMEOUT_CYCLES(100),
        .DWELL_CYCLES  (20),
        .GOOD_SAMPLES  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .temp_valid   (temp_valid),
        .temp_data    (temp_data),
        .temp_fault   (temp_fault),
        .setpoint     (setpoint),
        .hyst         (hyst),
        .status       (status),
        .heater_on    (heater_on),
        .cooler_on    (cooler_on),
        .status_change(status_change)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left on a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int d, input bit f);
        temp_valid = 1'b1;
        temp_data  = d[9:0];
        temp_fault = f;
        @(negedge clk);
        temp_valid = 1'b0;
        temp_fault = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input bit chg);
        check({tag, "_status"}, 32'(status), 32'(st));
        check({tag, "_heater"}, 32'(heater_on), 32'(st == 2'b01));
        check({tag, "_cooler"}, 32'(cooler_on), 32'(st == 2'b10));
        check({tag, "_change"}, 32'(status_change), 32'(chg));
    endtask

    initial begin
        @(negedge clk);
        idle(2);
        check_out("reset", 2'b00, 1'b0);
        reset = 1'b0;
        idle(25);

        // Heating entry and exit
        send(45, 1'b0);
        check_out("heat_on", 2'b01, 1'b1);
        idle(1);
        check("heat_pulse_once", 32'(status_change), 32'd0);
        idle(24);
        send(50, 1'b0);
        check_out("heat_off", 2'b00, 1'b1);

        // Cooling entry, hold, exit; band edges in IDLE
        idle(25);
        send(56, 1'b0);
        check_out("cool_on", 2'b10, 1'b1);
        idle(25);
        send(52, 1'b0);
        check_out("cool_hold", 2'b10, 1'b0);
        idle(25);
        send(50, 1'b0);
        check_out("cool_off", 2'b00, 1'b1);
        idle(25);
        send(54, 1'b0);
        check_out("band_hi", 2'b00, 1'b0);
        idle(5);
        send(46, 1'b0);
        check_out("band_lo", 2'b00, 1'b0);

        // Watchdog expiry exactly 100 cycles after the last sample
        idle(98);
        check("wd_before", 32'(status), 32'd0);
        idle(1);
        check("wd_tc_cycle", 32'(status), 32'd0);
        idle(1);
        check_out("wd_err", 2'b11, 1'b1);

        // Recovery with four clean samples
        for (int i = 0; i < 3; i++) begin
            idle(5);
            send(50, 1'b0);
            check("err_hold_clean", 32'(status), 32'd3);
        end
        idle(5);
        send(50, 1'b0);
        check_out("err_exit", 2'b00, 1'b1);

        // Fault entry, then an interrupted clean run
        idle(5);
        send(50, 1'b1);
        check_out("fault_err", 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(5);
            send(50, 1'b0);
        end
        idle(5);
        send(50, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(5);
            send(50, 1'b0);
        end
        check("err_after_fault", 32'(status), 32'd3);
        idle(5);
        send(50, 1'b0);
        check("err_exit2", 32'(status), 32'd0);

        // Faulty sample on the watchdog terminal cycle
        idle(99);
        send(50, 1'b1);
        check_out("tc_fault", 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(5);
            send(50, 1'b0);
        end
        check("tc_recover", 32'(status), 32'd0);

        // Clean sample on the terminal cycle suppresses the expiry
        idle(99);
        send(50, 1'b0);
        check_out("tc_clean", 2'b00, 1'b0);
        idle(2);
        check("tc_clean_after", 32'(status), 32'd0);

        // Dwell: exit sample 10 cycles after entry, then 25 cycles after
        send(45, 1'b0);
        check("dwell_enter", 32'(status), 32'd1);
        idle(9);
        send(50, 1'b0);
`ifdef TEMP_CTRL_DWELL_EN
        check("dwell_10", 32'(status), 32'd1);
`else
        check("dwell_10", 32'(status), 32'd0);
`endif
        idle(14);
        send(50, 1'b0);
        check("dwell_25", 32'(status), 32'd0);

        // Threshold clamps
        setpoint = 10'd2;
        hyst     = 6'd10;
        idle(25);
        send(0, 1'b0);
        check_out("lo_clamp", 2'b00, 1'b0);
        setpoint = 10'd1020;
        idle(5);
        send(1023, 1'b0);
        check_out("hi_clamp", 2'b00, 1'b0);

        // Reset while heating
        setpoint = 10'd50;
        hyst     = 6'd4;
        idle(25);
        send(45, 1'b0);
        check("pre_reset_heat", 32'(status), 32'd1);
        idle(2);
        reset = 1'b1;
        idle(1);
        check_out("mid_reset", 2'b00, 1'b0);
        reset = 1'b0;
        idle(1);
        check("post_reset_change", 32'(status_change), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
